// File: rtl/modulo_mef_dispensador_rolhas_pkg.sv
// rtl/modulo_mef_dispensador_rolhas_pkg.sv - shared definitions for the cork dispenser
package modulo_mef_dispensador_rolhas_pkg;

  // Default block parameters
  localparam int CAP_DEF    = 99;  // reservoir capacity in corks
  localparam int REFILL_DEF = 15;  // corks added per load event
  localparam int DOZEN_DEF  = 12;  // sealed bottles per box
  localparam int LOW_DEF    = 5;   // low-level threshold in corks

  localparam int CNT_RO_W = 7;
  localparam int CNT_DZ_W = 4;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISP     = 2'd1,
    ST_WAIT_REL = 2'd2,
    ST_BOX_FULL = 2'd3
  } state_e;

  // Reservoir update: optional load and optional take in the same cycle, saturated at cap.
  // A take only happens with a non-zero count, so the result never goes negative.
  function automatic logic [CNT_RO_W-1:0] ro_update(
    input logic [CNT_RO_W-1:0] cnt,
    input logic                load,
    input logic                take,
    input int                  refill,
    input int                  cap
  );
    int sum;
    sum = int'(cnt) + (load ? refill : 0) - (take ? 1 : 0);
    if (sum > cap) begin
      sum = cap;
    end
    if (sum < 0) begin
      sum = 0;
    end
    return sum[CNT_RO_W-1:0];
  endfunction

endpackage

// File: rtl/modulo_detector_borda.sv
// rtl/modulo_detector_borda.sv - rising-edge detector with freezable history
module modulo_detector_borda (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic d,
  output logic pulse
);

  logic d_hist_q;
  logic d_hist_d;

  // History only advances while the block is enabled
  always_comb begin
    d_hist_d = d_hist_q;
    if (enable) begin
      d_hist_d = d;
    end
  end

  // One-cycle-delayed copy of the input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_hist_q <= 1'b0;
    end else begin
      d_hist_q <= d_hist_d;
    end
  end

  assign pulse = enable & d & ~d_hist_q;

endmodule

// File: rtl/modulo_mef_dispensador_rolhas.sv
// rtl/modulo_mef_dispensador_rolhas.sv - cork dispenser controller with box counting
module modulo_mef_dispensador_rolhas
  import modulo_mef_dispensador_rolhas_pkg::*;
#(
  parameter int CAP    = CAP_DEF,
  parameter int REFILL = REFILL_DEF,
  parameter int DOZEN  = DOZEN_DEF,
  parameter int LOW    = LOW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                ve,
  input  logic                add,
  input  logic                cx,
  output logic                ro,
  output logic                dp,
  output logic                eb,
  output logic                al,
  output logic [CNT_RO_W-1:0] cnt_ro,
  output logic [CNT_DZ_W-1:0] cnt_dz
);

  state_e              state_q, state_d;
  logic [CNT_RO_W-1:0] cnt_ro_q, cnt_ro_d;
  logic [CNT_DZ_W-1:0] cnt_dz_q, cnt_dz_d;

  logic ve_pulse;
  logic add_pulse;
  logic cx_pulse;
  logic take;

  modulo_detector_borda u_det_ve (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .d      (ve),
    .pulse  (ve_pulse)
  );

  modulo_detector_borda u_det_add (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .d      (add),
    .pulse  (add_pulse)
  );

  modulo_detector_borda u_det_cx (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .d      (cx),
    .pulse  (cx_pulse)
  );

  // A cork is consumed only from IDLE with stock available
  always_comb begin
    take = enable && ve_pulse && (state_q == ST_IDLE) && (cnt_ro_q != '0);
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_ro_q <= '0;
      cnt_dz_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_ro_q <= cnt_ro_d;
      cnt_dz_q <= cnt_dz_d;
    end
  end

  // Next state and counter updates; everything holds while disabled
  always_comb begin
    state_d  = state_q;
    cnt_ro_d = cnt_ro_q;
    cnt_dz_d = cnt_dz_q;
    if (enable) begin
      // Loads are accepted in every state and may coincide with a take
      cnt_ro_d = ro_update(cnt_ro_q, add_pulse, take, REFILL, CAP);
      unique case (state_q)
        ST_IDLE: begin
          if (take) begin
            state_d  = ST_DISP;
            cnt_dz_d = cnt_dz_q + 1'b1;
          end
        end
        ST_DISP: begin
          if (cnt_dz_q == CNT_DZ_W'(DOZEN)) begin
            state_d = ST_BOX_FULL;
          end else begin
            state_d = ST_WAIT_REL;
          end
        end
        ST_WAIT_REL: begin
          // Wait for the seal command to drop so one command never takes two corks
          if (!ve) begin
            state_d = ST_IDLE;
          end
        end
        ST_BOX_FULL: begin
          if (cx_pulse) begin
            state_d  = ST_IDLE;
            cnt_dz_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    dp     = enable && (state_q == ST_DISP);
    eb     = (state_q == ST_BOX_FULL);
    ro     = enable && (cnt_ro_q != '0) &&
             ((state_q == ST_IDLE) || (state_q == ST_WAIT_REL));
    al     = (cnt_ro_q <= CNT_RO_W'(LOW));
    cnt_ro = cnt_ro_q;
    cnt_dz = cnt_dz_q;
  end

endmodule

// File: doc/modulo_mef_dispensador_rolhas.md
MODULO_MEF_DISPENSADOR_ROLHAS -- requirements
Module: modulo_mef_dispensador_rolhas

Interface
REQ-001 Parameters SHALL be (name, default, meaning): CAP, 99, reservoir capacity in corks.
REQ-002 Parameter SHALL be: REFILL, 15, corks added per load event.
REQ-003 Parameter SHALL be: DOZEN, 12, sealed bottles per box.
REQ-004 Parameter SHALL be: LOW, 5, low-level threshold in corks.
REQ-005 Port SHALL be: clk  input  1  single clock; all state changes on its rising edge.
REQ-006 Port SHALL be: rst  input  1  reset, asynchronous, active-high.
REQ-007 Port SHALL be: enable  input  1  1 = block operates; 0 = counters, FSM and edge history frozen.
REQ-008 Port SHALL be: ve  input  1  seal command from the fill/seal FSM; each 0->1 edge requests one cork.
REQ-009 Port SHALL be: add  input  1  operator cork-load button; each 0->1 edge adds REFILL corks.
REQ-010 Port SHALL be: cx  input  1  box-swapped acknowledge; a 0->1 edge while box full restarts the count.
REQ-011 Port SHALL be: ro  output  1  cork available to the sealer.
REQ-012 Port SHALL be: dp  output  1  one-cycle dispense-actuator pulse per consumed cork.
REQ-013 Port SHALL be: eb  output  1  box full; the line is blocked.
REQ-014 Port SHALL be: al  output  1  low-reservoir alarm.
REQ-015 Port SHALL be: cnt_ro  output  7  corks in reservoir, 0..CAP.
REQ-016 Port SHALL be: cnt_dz  output  4  bottles in current box, 0..DOZEN.

Function
REQ-017 FSM states SHALL be: IDLE, DISP, WAIT_REL, BOX_FULL.
REQ-018 IDLE -> DISP SHALL occur on a ve rising edge when cnt_ro>0; cnt_ro decrements and cnt_dz increments on that same edge.
REQ-019 A ve rising edge in IDLE with cnt_ro=0 SHALL be ignored: state, cnt_ro and cnt_dz are unchanged.
REQ-020 DISP SHALL last exactly one cycle with dp=1; dp SHALL be 0 in every other state.
REQ-021 DISP SHALL go to BOX_FULL if cnt_dz=DOZEN, else to WAIT_REL.
REQ-022 WAIT_REL SHALL go to IDLE when ve=0; further ve activity in WAIT_REL SHALL consume nothing.
REQ-023 BOX_FULL SHALL hold eb=1 and cnt_dz=DOZEN, and SHALL ignore ve edges; a cx rising edge SHALL clear cnt_dz to 0 and return to IDLE.
REQ-024 Edge detection SHALL compare against a one-cycle-delayed register of each input, so the response follows the edge by 1 cycle.
REQ-025 Load: on an add rising edge, cnt_ro SHALL become min(cnt_ro+REFILL, CAP) in any state.
REQ-026 If an add edge and a consuming ve edge coincide, cnt_ro SHALL become min(cnt_ro+REFILL-1, CAP).
REQ-027 ro SHALL equal enable and (cnt_ro>0) and (state is IDLE or WAIT_REL), combinationally.
REQ-028 al SHALL equal (cnt_ro<=LOW), combinationally, independent of enable.
REQ-029 With enable=0, all registers including edge history SHALL hold, ro SHALL be 0, and dp SHALL be 0.

Reset
REQ-030 When rst=1, the block SHALL immediately enter IDLE with cnt_ro=0, cnt_dz=0, dp=0, eb=0 and edge history 0, which gives ro=0 and al=1.
REQ-031 Reset asserted mid-DISP or in BOX_FULL SHALL abort the operation with no count restored.

Structure
REQ-032 State encodings and the defaults of CAP, REFILL, DOZEN and LOW SHALL reside in the shared project definitions include file.
REQ-033 Rising-edge detection SHALL use one sub-module, modulo_detector_borda (clk, rst, enable, d -> pulse), instantiated for ve, add and cx.

Verification
REQ-034 Reset, then one add pulse -> cnt_ro=15, al=0, ro=1.
REQ-035 cnt_ro=3, then ve held high for 5 cycles -> exactly one dp pulse; cnt_ro=2, cnt_dz=1; return to IDLE after ve falls.
REQ-036 cnt_ro=0, then a ve pulse -> ro=0, dp never asserted, counts unchanged.
REQ-037 cnt_ro=95, then add -> cnt_ro=99; with cnt_ro=90, add and a ve edge in the same cycle -> cnt_ro=99.
REQ-038 Twelve ve pulses from cnt_dz=0 -> eb=1 after the 12th; a 13th ve pulse is ignored (cnt_ro unchanged); cx pulse -> cnt_dz=0, eb=0.
REQ-039 enable=0 during a ve edge -> no count change; rst asserted in BOX_FULL -> IDLE, eb=0, cnt_dz=0 without waiting for a clock edge.
